// File: rtl/progdump_if.sv
// Bundle joining progdump to its trigger source, the instruction-memory read port
// and the debug uarttx handshake.
interface progdump_if #(
  parameter int CNTW = 16
);
  logic            trig;
  logic [31:0]     startaddr;
  logic [CNTW-1:0] nwords;
  logic            abort;
  logic            busy;
  logic            mem_r_en;
  logic [31:0]     mem_r_addr;
  logic [31:0]     mem_r_data;
  logic [7:0]      charout;
  logic            uarttxen;
  logic            uartbusy;

  modport slave (
    input  trig, startaddr, nwords, abort, mem_r_data, uartbusy,
    output busy, mem_r_en, mem_r_addr, charout, uarttxen
  );

  modport master (
    output trig, startaddr, nwords, abort, mem_r_data, uartbusy,
    input  busy, mem_r_en, mem_r_addr, charout, uarttxen
  );
endinterface

// File: rtl/progdump.sv
// Program-memory readback engine: reads a range of instruction words and sends each
// one over uarttx as "AAAAAAAA:DDDDDDDD\r\n" in uppercase hex.
module progdump #(
  parameter int CNTW  = 16,
  parameter int RDLAT = 1
) (
  input logic        clk,
  input logic        n_rst,
  progdump_if.slave  io_bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_WAITRD = 3'd2;
  localparam logic [2:0] S_EMIT   = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_WAITTX = 3'd5;
  localparam logic [2:0] S_NEXT   = 3'd6;

  localparam logic [4:0]      LAST_IDX = 5'd18;
  localparam logic [1:0]      LAT      = 2'(RDLAT);
  localparam logic [CNTW-1:0] ONE_WORD = CNTW'(1);

  logic [2:0]      r_state;
  logic [31:0]     r_addr;
  logic [31:0]     r_data;
  logic [CNTW-1:0] r_remaining;
  logic [4:0]      r_idx;
  logic [1:0]      r_lat;
  logic            r_abort;
  logic            r_busy;
  logic            r_mem_r_en;
  logic [31:0]     r_mem_r_addr;
  logic [7:0]      r_charout;
  logic            r_uarttxen;

  logic            w_abort_seen;
  logic [7:0]      w_char;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h37 + {4'h0, nib};
    end
  endfunction

  // Character idx of a line: 0-7 address nibbles, 8 ':', 9-16 data nibbles, 17 CR, 18 LF.
  function automatic logic [7:0] line_char(input logic [31:0] addr,
                                           input logic [31:0] data,
                                           input logic [4:0]  idx);
    logic [7:0] c;
    c = 8'h00;
    if (idx < 5'd8) begin
      c = hex_char(4'(addr >> (5'd28 - {idx[2:0], 2'b00})));
    end else if (idx == 5'd8) begin
      c = 8'h3A;
    end else if (idx < 5'd17) begin
      c = hex_char(4'(data >> (5'd28 - {idx[2:0] - 3'd1, 2'b00})));
    end else if (idx == 5'd17) begin
      c = 8'h0D;
    end else begin
      c = 8'h0A;
    end
    return c;
  endfunction

  // Abort may arrive in the very cycle WAITTX sees the transmitter go idle.
  always_comb begin
    w_abort_seen = r_abort | io_bus.abort;
    w_char       = line_char(r_addr, r_data, r_idx);
  end

  // Dump sequencer: read word, emit 19 characters with transmitter handshake, advance.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state      <= S_IDLE;
      r_addr       <= 32'h0000_0000;
      r_data       <= 32'h0000_0000;
      r_remaining  <= '0;
      r_idx        <= 5'd0;
      r_lat        <= 2'd0;
      r_abort      <= 1'b0;
      r_busy       <= 1'b0;
      r_mem_r_en   <= 1'b0;
      r_mem_r_addr <= 32'h0000_0000;
      r_charout    <= 8'h00;
      r_uarttxen   <= 1'b0;
    end else begin
      if ((r_state != S_IDLE) && io_bus.abort) begin
        r_abort <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (io_bus.trig && (io_bus.nwords != '0)) begin
            r_addr      <= io_bus.startaddr & 32'hFFFF_FFFC;
            r_remaining <= io_bus.nwords;
            r_busy      <= 1'b1;
            r_state     <= S_READ;
          end
        end
        S_READ: begin
          r_mem_r_en   <= 1'b1;
          r_mem_r_addr <= r_addr;
          r_lat        <= 2'd0;
          r_state      <= S_WAITRD;
        end
        S_WAITRD: begin
          r_mem_r_en <= 1'b0;
          if (r_lat == LAT) begin
            r_data  <= io_bus.mem_r_data;
            r_idx   <= 5'd0;
            r_state <= S_EMIT;
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        S_EMIT: begin
          if (!io_bus.uartbusy) begin
            r_charout  <= w_char;
            r_uarttxen <= 1'b1;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Guard cycle so the transmitter's busy flag is visible before WAITTX.
          r_uarttxen <= 1'b0;
          r_state    <= S_WAITTX;
        end
        S_WAITTX: begin
          if (!io_bus.uartbusy) begin
            if (w_abort_seen) begin
              r_abort <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else if (r_idx < LAST_IDX) begin
              r_idx   <= r_idx + 5'd1;
              r_state <= S_EMIT;
            end else begin
              r_state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          r_remaining <= r_remaining - ONE_WORD;
          r_addr      <= r_addr + 32'd4;
          if (r_remaining == ONE_WORD) begin
            r_abort <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_READ;
          end
        end
        default: begin
          r_abort    <= 1'b0;
          r_busy     <= 1'b0;
          r_mem_r_en <= 1'b0;
          r_uarttxen <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.busy       = r_busy;
  assign io_bus.mem_r_en   = r_mem_r_en;
  assign io_bus.mem_r_addr = r_mem_r_addr;
  assign io_bus.charout    = r_charout;
  assign io_bus.uarttxen   = r_uarttxen;
endmodule

// File: tb/tb_progdump.sv
// Bench for progdump: memory and uarttx models, a line-format reference model built
// from address/data text, table vectors, hand-written corner sequences and random dumps.
module tb_progdump;
  localparam int CNTW  = 16;
  localparam int RDLAT = 1;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  progdump_if #(.CNTW(CNTW)) bus ();
  progdump #(.CNTW(CNTW), .RDLAT(RDLAT)) dut (.clk(clk), .n_rst(n_rst), .io_bus(bus.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Instruction memory with RDLAT-cycle read pipeline
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_pipe [RDLAT];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_C3C3;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_r_en) rd_pipe[0] <= mem_word(bus.mem_r_addr);
    for (int i = 1; i < RDLAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_r_data = rd_pipe[RDLAT-1];

  // Transmitter model: busy for bp_len cycles (or a random length up to it) after each strobe
  int tx_cnt = 0;
  int bp_len = 0;
  bit bp_rand = 1'b0;
  always @(posedge clk) begin
    if (bus.uarttxen) tx_cnt <= bp_rand ? int'($urandom_range(bp_len)) : bp_len;
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
  end
  assign bus.uartbusy = (tx_cnt != 0);

  // Monitor: capture characters and read addresses, count protocol violations
  logic [7:0]  got_q[$];
  logic [31:0] rda_q[$];
  int viol = 0;
  int cyc = 0;
  int last_stb = -100;
  bit prev_txen = 1'b0;
  bit prev_ren = 1'b0;
  always @(negedge clk) begin
    if (bus.uarttxen) begin
      got_q.push_back(bus.charout);
      if (bus.uartbusy) viol++;
      if (prev_txen) viol++;
      if (cyc - last_stb < 3) viol++;
      last_stb = cyc;
    end
    if (bus.mem_r_en) begin
      rda_q.push_back(bus.mem_r_addr);
      if (bus.uartbusy || bus.uarttxen) viol++;
      if (prev_ren) viol++;
    end
    prev_txen = bus.uarttxen;
    prev_ren  = bus.mem_r_en;
    cyc++;
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_r_en"},   32'(bus.mem_r_en), 32'd0);
    chk({tag, "_mem_r_addr"}, bus.mem_r_addr,    32'd0);
    chk({tag, "_charout"},    32'(bus.charout),  32'd0);
    chk({tag, "_uarttxen"},   32'(bus.uarttxen), 32'd0);
    chk({tag, "_busy"},       32'(bus.busy),     32'd0);
  endtask

  task automatic run_dump(input string tag, input logic [31:0] sa, input int n, input int bp,
                          input bit rnd, input int abort_at, input int retrig_at,
                          input int rst_at, input bit ab_trig);
    int limit;
    int c;
    bit ab_done;
    bit rst_done;
    bit rst_pend;
    ab_done = 1'b0; rst_done = 1'b0; rst_pend = 1'b0;
    for (int k = 0; k < 2000 && bus.uartbusy; k++) @(negedge clk);
    @(negedge clk); #1;
    got_q.delete(); rda_q.delete(); viol = 0;
    bp_len = bp; bp_rand = rnd;
    bus.startaddr = sa; bus.nwords = CNTW'(n); bus.trig = 1'b1; bus.abort = ab_trig;
    @(negedge clk); #1;
    bus.trig = 1'b0; bus.abort = 1'b0;
    chk({tag, "_busy_rise"}, 32'(bus.busy), (n != 0) ? 32'd1 : 32'd0);
    limit = (n * 19 + 4) * (bp + 6) + 50;
    c = 0;
    while ((bus.busy || rst_pend) && c < limit) begin
      @(negedge clk); #1;
      c++;
      if (rst_pend) begin
        n_rst = 1'b1;
        chk_reset_outputs({tag, "_midrst"});
        rst_pend = 1'b0;
      end
      bus.abort = 1'b0;
      bus.trig  = 1'b0;
      if (abort_at > 0 && !ab_done && got_q.size() == abort_at) begin
        bus.abort = 1'b1; ab_done = 1'b1;
      end
      if (retrig_at > 0 && got_q.size() == retrig_at) begin
        bus.trig = 1'b1; bus.startaddr = 32'h0000_0800; bus.nwords = CNTW'(5);
      end
      if (rst_at > 0 && !rst_done && got_q.size() == rst_at) begin
        n_rst = 1'b0; rst_done = 1'b1; rst_pend = 1'b1;
      end
    end
    bus.abort = 1'b0; bus.trig = 1'b0;
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    if (rst_at == 0 && n != 0) chk({tag, "_uartbusy_at_end"}, 32'(bus.uartbusy), 32'd0);
    repeat (6) @(negedge clk);
    #1;
    chk({tag, "_busy_stays_low"}, 32'(bus.busy), 32'd0);
  endtask

  // Reference: build the expected text of every line, truncate at stop characters
  task automatic compare_run(input string tag, input logic [31:0] sa, input int n, input int stop,
                             input int exp_strobes, input int exp_reads);
    logic [7:0]  exp_c[$];
    logic [31:0] exp_a[$];
    logic [31:0] a;
    string s;
    int nrd;
    a = sa & 32'hFFFF_FFFC;
    for (int w = 0; w < n; w++) begin
      exp_a.push_back(a);
      s = $sformatf("%08h:%08h", a, mem_word(a));
      s = s.toupper();
      for (int i = 0; i < s.len(); i++) exp_c.push_back(s[i]);
      exp_c.push_back(8'h0D);
      exp_c.push_back(8'h0A);
      a = a + 32'd4;
    end
    if (stop > 0) begin
      while (exp_c.size() > stop) void'(exp_c.pop_back());
      nrd = (stop + 18) / 19;
      while (exp_a.size() > nrd) void'(exp_a.pop_back());
    end
    chk({tag, "_strobes"}, 32'(got_q.size()), 32'(exp_strobes));
    chk({tag, "_reads"},   32'(rda_q.size()), 32'(exp_reads));
    chk({tag, "_model_len"}, 32'(got_q.size()), 32'(exp_c.size()));
    for (int i = 0; i < got_q.size() && i < exp_c.size(); i++)
      chk($sformatf("%s_char%0d", tag, i), 32'(got_q[i]), 32'(exp_c[i]));
    for (int i = 0; i < rda_q.size() && i < exp_a.size(); i++)
      chk($sformatf("%s_raddr%0d", tag, i), rda_q[i], exp_a[i]);
    chk({tag, "_protocol"}, 32'(viol), 32'd0);
  endtask

  typedef struct {
    logic [31:0] sa;
    int          n;
    logic [31:0] d0;
    int          bp;
    int          abort_at;
    int          exp_strobes;
    int          exp_reads;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] a;
    logic [31:0] sa;
    int n;
    int ab;
    int bp;

    vecs[0] = '{32'h0000_0010, 1, 32'hDEAD_BEEF, 0,   0, 19, 1};
    vecs[1] = '{32'h0000_0013, 3, 32'h0000_0001, 2,   0, 57, 3};
    vecs[2] = '{32'hFFFF_FFFC, 2, 32'hCAFE_F00D, 1,   0, 38, 2};
    vecs[3] = '{32'h0000_0100, 1, 32'h0123_ABCD, 520, 0, 19, 1};
    vecs[4] = '{32'h0000_0200, 2, 32'h89AB_CDEF, 6,   5, 5,  1};
    vecs[5] = '{32'h0000_0500, 0, 32'h1111_2222, 0,   0, 0,  0};

    n_rst = 1'b0;
    bus.trig = 1'b0; bus.abort = 1'b0; bus.startaddr = 32'd0; bus.nwords = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    n_rst = 1'b1;

    for (int v = 0; v < 6; v++) begin
      a = vecs[v].sa & 32'hFFFF_FFFC;
      for (int w = 0; w < vecs[v].n; w++) begin
        mem[a] = vecs[v].d0 + 32'(w);
        a = a + 32'd4;
      end
      run_dump($sformatf("vec%0d", v), vecs[v].sa, vecs[v].n, vecs[v].bp, 1'b0,
               vecs[v].abort_at, 0, 0, 1'b0);
      compare_run($sformatf("vec%0d", v), vecs[v].sa, vecs[v].n, vecs[v].abort_at,
                  vecs[v].exp_strobes, vecs[v].exp_reads);
    end

    // Trigger while busy must not relatch address or count
    mem[32'h40] = 32'h0BAD_F00D; mem[32'h44] = 32'h7654_3210;
    run_dump("retrig", 32'h0000_0040, 2, 2, 1'b0, 0, 3, 0, 1'b0);
    compare_run("retrig", 32'h0000_0040, 2, 0, 38, 2);

    // Reset during the 7th character truncates the line
    mem[32'h300] = 32'hA1B2_C3D4; mem[32'h304] = 32'h5E6F_7081;
    run_dump("midrst", 32'h0000_0300, 2, 3, 1'b0, 0, 0, 7, 1'b0);
    compare_run("midrst", 32'h0000_0300, 2, 7, 7, 1);

    // Trigger and abort together in IDLE: trigger wins, full line follows the reset
    run_dump("trigabort", 32'h0000_0304, 1, 1, 1'b0, 0, 0, 0, 1'b1);
    compare_run("trigabort", 32'h0000_0304, 1, 0, 19, 1);

    for (int r = 0; r < 8; r++) begin
      sa = $urandom();
      n  = int'($urandom_range(3, 1));
      bp = int'($urandom_range(12));
      ab = ($urandom_range(1) == 1) ? int'($urandom_range(n * 19, 1)) : 0;
      a = sa & 32'hFFFF_FFFC;
      for (int w = 0; w < n; w++) begin
        mem[a] = $urandom();
        a = a + 32'd4;
      end
      run_dump($sformatf("rnd%0d", r), sa, n, bp, 1'b1, ab, 0, 0, 1'b0);
      compare_run($sformatf("rnd%0d", r), sa, n, ab,
                  (ab > 0) ? ab : n * 19, (ab > 0) ? (ab + 18) / 19 : n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
